ysyx_25040105_fetch_decode_exec: RTL and testbench

Single-cycle RV32I fetch/decode/execute datapath for the ysyx_25040105 SoC top. It holds the program counter and drives the fetch address. It decodes the instruction returned for that address and computes ALU, branch/jump, load and store results. Register file and memories sit outside the block and are reached through combinational read ports and registered-by-consumer write strobes.

---
 rtl/ysyx_25040105_fetch_decode_exec_if.sv | 33 +++
 rtl/ysyx_25040105_fetch_decode_exec.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_25040105_fetch_decode_exec.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040105_fetch_decode_exec_if.sv
// Signal bundle between the RV32I core and its register file / memory environment.
// The core drives through master; the environment side uses slave.
interface ysyx_25040105_fetch_decode_exec_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        reg_wen;
  logic [31:0] reg_wdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_len;
  logic [31:0] mem_rdata;
  logic [31:0] mem_data;
  logic        is_ebreak;
  logic        illegal;

  modport master (
    output pc, rs1, rs2, rd, reg_wen, reg_wdata, mem_ren, mem_wen, mem_addr, mem_len,
           mem_data, is_ebreak, illegal,
    input  inst, rs1_data, rs2_data, mem_rdata
  );

  modport slave (
    input  pc, rs1, rs2, rd, reg_wen, reg_wdata, mem_ren, mem_wen, mem_addr, mem_len,
           mem_data, is_ebreak, illegal,
    output inst, rs1_data, rs2_data, mem_rdata
  );
endinterface

// File: rtl/ysyx_25040105_fetch_decode_exec.sv
// Single-cycle RV32I fetch/decode/execute datapath; the PC is the only state.
// Register file and memories live outside and are reached through the bus interface.
module ysyx_25040105_fetch_decode_exec (
  input logic clk,
  input logic rst,
  ysyx_25040105_fetch_decode_exec_if.master bus
);
  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [2:0] {WbAlu, WbImm, WbPcImm, WbPc4, WbLoad} wb_sel_e;

  localparam logic [31:0] ResetPc    = 32'h8000_0000;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [6:0]  OpLui      = 7'b0110111;
  localparam logic [6:0]  OpAuipc    = 7'b0010111;
  localparam logic [6:0]  OpJal      = 7'b1101111;
  localparam logic [6:0]  OpJalr     = 7'b1100111;
  localparam logic [6:0]  OpBranch   = 7'b1100011;
  localparam logic [6:0]  OpLoad     = 7'b0000011;
  localparam logic [6:0]  OpStore    = 7'b0100011;
  localparam logic [6:0]  OpImm      = 7'b0010011;
  localparam logic [6:0]  OpReg      = 7'b0110011;

  logic [31:0] pc_q, pc_d, pc_plus4, inst, a, b;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm, alu_b, alu_result, load_data;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        use_rs2, legal, wr_reg, is_load, is_store, is_jal, is_jalr, is_branch;
  logic        ebreak, taken;

  assign inst     = bus.inst;
  assign a        = bus.rs1_data;
  assign b        = bus.rs2_data;
  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign pc_plus4 = pc_q + 32'd4;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // alt selects SUB/SRA over ADD/SRL
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  always_comb begin
    imm       = imm_i;
    alu_op    = AluAdd;
    use_rs2   = 1'b0;
    legal     = 1'b1;
    wr_reg    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    ebreak    = 1'b0;
    wb_sel    = WbAlu;
    case (opcode)
      OpLui:    begin imm = imm_u; wr_reg = 1'b1; wb_sel = WbImm; end
      OpAuipc:  begin imm = imm_u; wr_reg = 1'b1; wb_sel = WbPcImm; end
      OpJal:    begin imm = imm_j; wr_reg = 1'b1; wb_sel = WbPc4; is_jal = 1'b1; end
      OpJalr: begin
        legal   = (funct3 == 3'b000);
        wr_reg  = legal;
        is_jalr = legal;
        wb_sel  = WbPc4;
      end
      OpBranch: begin
        imm       = imm_b;
        legal     = (funct3[2:1] != 2'b01);
        is_branch = legal;
      end
      OpLoad: begin
        legal   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        wr_reg  = legal;
        is_load = legal;
        wb_sel  = WbLoad;
      end
      OpStore: begin
        imm      = imm_s;
        legal    = funct3 inside {3'b000, 3'b001, 3'b010};
        is_store = legal;
      end
      OpImm: begin
        // funct7 only qualifies the shift forms; ADDI with a negative imm is still ADD
        alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  legal = (funct7 == 7'h00);
          3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
        wr_reg = legal;
      end
      OpReg: begin
        use_rs2 = 1'b1;
        alu_op  = alu_from_f3(funct3, funct7[5]);
        legal   = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        wr_reg  = legal;
      end
      default: begin
        legal  = (inst == InstEbreak);
        ebreak = legal;
      end
    endcase
  end

  assign alu_b = use_rs2 ? b : imm;

  always_comb begin
    unique case (alu_op)
      AluSub:  alu_result = a - alu_b;
      AluSll:  alu_result = a << alu_b[4:0];
      AluSlt:  alu_result = {31'b0, $signed(a) < $signed(alu_b)};
      AluSltu: alu_result = {31'b0, a < alu_b};
      AluXor:  alu_result = a ^ alu_b;
      AluSrl:  alu_result = a >> alu_b[4:0];
      AluSra:  alu_result = $unsigned($signed(a) >>> alu_b[4:0]);
      AluOr:   alu_result = a | alu_b;
      AluAnd:  alu_result = a & alu_b;
      default: alu_result = a + alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a < b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      3'b001:  load_data = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b100:  load_data = {24'b0, bus.mem_rdata[7:0]};
      3'b101:  load_data = {16'b0, bus.mem_rdata[15:0]};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WbImm:   bus.reg_wdata = imm;
      WbPcImm: bus.reg_wdata = pc_q + imm;
      WbPc4:   bus.reg_wdata = pc_plus4;
      WbLoad:  bus.reg_wdata = load_data;
      default: bus.reg_wdata = alu_result;
    endcase
    pc_d = pc_plus4;
    if (is_jal || (is_branch && taken)) begin
      pc_d = pc_q + imm;
    end else if (is_jalr) begin
      pc_d = (a + imm) & ~32'h1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.rs1       = inst[19:15];
  assign bus.rs2       = inst[24:20];
  assign bus.rd        = inst[11:7];
  assign bus.reg_wen   = wr_reg && (inst[11:7] != 5'd0);
  assign bus.mem_ren   = is_load;
  assign bus.mem_wen   = is_store;
  assign bus.mem_addr  = a + imm;
  assign bus.mem_len   = (funct3[1:0] == 2'b00) ? 32'd1 :
                         (funct3[1:0] == 2'b01) ? 32'd2 : 32'd4;
  assign bus.mem_data  = b;
  assign bus.is_ebreak = ebreak;
  assign bus.illegal   = ~legal;
endmodule

// File: tb/tb_ysyx_25040105_fetch_decode_exec.sv
// Directed bench: expectations are queued when an instruction is driven and
// drained against the DUT once its combinational outputs have settled.
module tb_ysyx_25040105_fetch_decode_exec;
  logic clk = 1'b0;
  logic rst;

  ysyx_25040105_fetch_decode_exec_if bus ();

  ysyx_25040105_fetch_decode_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {
    SPc, SRd, SRegWen, SWdata, SMemRen, SMemWen, SAddr, SLen, SData, SEbreak, SIllegal
  } sel_e;

  typedef struct {
    string       step;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  string       step;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      SPc:      return bus.pc;
      SRd:      return 32'(bus.rd);
      SRegWen:  return 32'(bus.reg_wen);
      SWdata:   return bus.reg_wdata;
      SMemRen:  return 32'(bus.mem_ren);
      SMemWen:  return 32'(bus.mem_wen);
      SAddr:    return bus.mem_addr;
      SLen:     return bus.mem_len;
      SData:    return bus.mem_data;
      SEbreak:  return 32'(bus.is_ebreak);
      default:  return 32'(bus.illegal);
    endcase
  endfunction

  task automatic push(input sel_e s, input logic [31:0] v);
    exp_t e;
    e.step = step;
    e.sel  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s.%s: got %h required %h", e.step, e.sel.name(), obs, e.exp);
      end
    end
  endtask

  task automatic drive(input string name, input logic [31:0] i, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] md);
    step          = name;
    bus.inst      = i;
    bus.rs1_data  = r1;
    bus.rs2_data  = r2;
    bus.mem_rdata = md;
  endtask

  // Advance one instruction and check the resulting PC.
  task automatic tick_pc(input logic [31:0] next);
    exp_pc = next;
    @(posedge clk);
    #1;
    push(SPc, exp_pc);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    drive("reset", 32'h0000_0013, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    push(SPc, 32'h8000_0000);
    drain();
    rst = 1'b0;

    drive("addi", 32'h0050_0093, 32'h0, 32'h0, 32'h0);
    push(SRegWen, 1); push(SRd, 1); push(SWdata, 32'd5); push(SIllegal, 0);
    #1 drain();
    tick_pc(32'h8000_0004);

    // asynchronous reset between edges
    step = "async_rst";
    #2 rst = 1'b1;
    push(SPc, 32'h8000_0000);
    #1 drain();
    tick_pc(32'h8000_0000);
    rst = 1'b0;

    drive("sub", 32'h4020_81B3, 32'd3, 32'd5, 32'h0);
    push(SWdata, 32'hFFFF_FFFE); push(SRd, 3);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("sra", 32'h4020_D1B3, 32'h8000_0000, 32'h24, 32'h0);
    push(SWdata, 32'hF800_0000);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("srai", 32'h4040_D193, 32'h8000_0000, 32'h0, 32'h0);
    push(SWdata, 32'hF800_0000); push(SIllegal, 0);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("sltu", 32'h0020_B1B3, 32'd1, 32'hFFFF_FFFF, 32'h0);
    push(SWdata, 32'd1);
    #1 drain();
    tick_pc(32'h8000_0010);

    drive("jal", 32'h0200_00EF, 32'h0, 32'h0, 32'h0);
    push(SWdata, 32'h8000_0014); push(SRegWen, 1);
    #1 drain();
    tick_pc(32'h8000_0030);

    drive("jalr", 32'h0002_80E7, 32'h8000_0101, 32'h0, 32'h0);
    push(SWdata, 32'h8000_0034);
    #1 drain();
    tick_pc(32'h8000_0100);

    drive("jalr2", 32'h0002_80E7, 32'h8000_0020, 32'h0, 32'h0);
    #1 drain();
    tick_pc(32'h8000_0020);

    drive("beq", 32'hFE20_8CE3, 32'd7, 32'd7, 32'h0);
    push(SRegWen, 0); push(SMemWen, 0);
    #1 drain();
    tick_pc(32'h8000_0018);

    drive("blt", 32'h0020_C463, 32'hFFFF_FFFF, 32'd1, 32'h0);
    #1 drain();
    tick_pc(32'h8000_0020);

    drive("bltu", 32'h0020_E463, 32'hFFFF_FFFF, 32'd1, 32'h0);
    #1 drain();
    tick_pc(32'h8000_0024);

    drive("sb", 32'h0020_81A3, 32'h8000_1000, 32'hAABB_CCDD, 32'h0);
    push(SMemWen, 1); push(SMemRen, 0); push(SAddr, 32'h8000_1003); push(SLen, 32'd1);
    push(SRegWen, 0); push(SData, 32'hAABB_CCDD);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("lb", 32'h0000_8183, 32'h8000_2000, 32'h0, 32'h0000_0080);
    push(SWdata, 32'hFFFF_FF80); push(SMemRen, 1); push(SMemWen, 0); push(SLen, 32'd1);
    push(SRegWen, 1); push(SAddr, 32'h8000_2000);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("lbu", 32'h0000_C183, 32'h8000_2000, 32'h0, 32'h0000_0080);
    push(SWdata, 32'h0000_0080);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("lh", 32'h0000_9183, 32'h8000_2000, 32'h0, 32'h0000_8000);
    push(SWdata, 32'hFFFF_8000); push(SLen, 32'd2);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("lui", 32'h1234_50B7, 32'h0, 32'h0, 32'h0);
    push(SWdata, 32'h1234_5000); push(SRegWen, 1);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("auipc", 32'h0000_1097, 32'h0, 32'h0, 32'h0);
    push(SWdata, exp_pc + 32'h1000);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("ebreak", 32'h0010_0073, 32'h0, 32'h0, 32'h0);
    push(SEbreak, 1); push(SRegWen, 0); push(SMemWen, 0); push(SMemRen, 0); push(SIllegal, 0);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("illegal", 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    push(SIllegal, 1); push(SRegWen, 0); push(SMemWen, 0); push(SMemRen, 0); push(SEbreak, 0);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("rd_x0", 32'h0050_0013, 32'h0, 32'h0, 32'h0);
    push(SRegWen, 0); push(SIllegal, 0);
    #1 drain();
    tick_pc(exp_pc + 4);

    drive("jalr_top", 32'h0002_8067, 32'hFFFF_FFFC, 32'h0, 32'h0);
    push(SRegWen, 0);
    #1 drain();
    tick_pc(32'hFFFF_FFFC);

    drive("wrap", 32'h0000_0013, 32'h0, 32'h0, 32'h0);
    #1 drain();
    tick_pc(32'h0000_0000);

    step = "async_rst2";
    #2 rst = 1'b1;
    push(SPc, 32'h8000_0000);
    #1 drain();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
